// File: rtl/bp_be_rec_to_fp_pipe.sv
// ---------------------------------------------------------------------------
// bp_be_rec_to_fp_pipe
//
// Converts a 65-bit HardFloat recoded double into an IEEE-754 raw bit
// pattern. The result is either a double or a single NaN-boxed into 64 bits.
// The converted value and its valid bit travel through num_stages_p register
// stages; num_stages_p = 0 gives a purely combinational path. A saturating
// counter tallies the valid results that leave the pipeline.
//
// Optional feature macro: BP_REC_TO_FP_CANON_NAN_EN
//   When defined, every NaN input is replaced by the RISC-V canonical NaN
//   (DP 64'h7FF8_0000_0000_0000, SP 32'h7FC0_0000 NaN-boxed).
//   When undefined, the NaN sign and payload pass through.
//
// Ports:
//   clk_i        in  1   clock
//   reset_n_i    in  1   asynchronous active-low reset
//   v_i          in  1   input valid
//   rec_i        in  65  recoded double {sign, exp[11:0], frac[51:0]}
//   sp_not_dp_i  in  1   1: NaN-boxed single result, 0: double result
//   clear_i      in  1   synchronous counter clear (wins over increment)
//   v_o          out 1   output valid
//   raw_o        out 64  IEEE raw result
//   count_o      out clog2(max_val_p+1)  conversions that left the pipeline
// ---------------------------------------------------------------------------
module bp_be_rec_to_fp_pipe #(
    parameter int num_stages_p = 4,
    parameter int max_val_p    = 2**30,
    localparam int count_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [64:0]               rec_i,
    input  logic                      sp_not_dp_i,
    input  logic                      clear_i,
    output logic                      v_o,
    output logic [63:0]               raw_o,
    output logic [count_width_lp-1:0] count_o
);

    // -----------------------------------------------------------------------
    // Field decode
    // -----------------------------------------------------------------------
    logic        sign;
    logic [11:0] rec_exp;
    logic [51:0] frac;
    logic [2:0]  kind;

    assign sign    = rec_i[64];
    assign rec_exp = rec_i[63:52];
    assign frac    = rec_i[51:0];
    assign kind    = rec_exp[11:9];

    // The unbiased exponent is E = rec_exp - 2048.
    // DP normal when E >= -1022, i.e. rec_exp >= 1026; biased field = rec_exp - 1025.
    // SP normal when E >= -126,  i.e. rec_exp >= 1922; biased field = rec_exp - 1921.
    // Only the low bits of the biased exponent are kept, so the subtraction is
    // done directly at field width (1921 mod 256 = 129).
    logic        dp_normal;
    logic        sp_normal;
    logic [10:0] dp_biased;
    logic [7:0]  sp_biased;

    assign dp_normal = (rec_exp >= 12'd1026);
    assign sp_normal = (rec_exp >= 12'd1922);
    assign dp_biased = rec_exp[10:0] - 11'd1025;
    assign sp_biased = rec_exp[7:0]  - 8'd129;

    // Subnormal fraction: the significand {1,frac} shifted right by the
    // distance below the minimum normal exponent (-1022-E for DP, -126-E for
    // SP). Shifts past the significand width naturally produce zero, which
    // covers values too small for the target format. Low bits are truncated.
    logic [11:0] dp_shift;
    logic [11:0] sp_shift;
    logic [52:0] dp_mant;
    logic [23:0] sp_mant;
    logic [51:0] dp_sub;
    logic [22:0] sp_sub;

    assign dp_shift = 12'd1026 - rec_exp;
    assign sp_shift = 12'd1922 - rec_exp;
    assign dp_mant  = {1'b1, frac};
    assign sp_mant  = {1'b1, frac[51:29]};
    assign dp_sub   = 52'(dp_mant >> dp_shift);
    assign sp_sub   = 23'(sp_mant >> sp_shift);

    // -----------------------------------------------------------------------
    // Encode
    // -----------------------------------------------------------------------
    logic [63:0] dp_raw;
    logic [31:0] sp_raw;
    logic [63:0] raw_comb;

    always_comb begin
        dp_raw = '0;
        sp_raw = '0;
        case (kind)
            3'b000: begin
                dp_raw = {sign, 63'b0};
                sp_raw = {sign, 31'b0};
            end
            3'b110: begin
                dp_raw = {sign, 11'h7FF, 52'b0};
                sp_raw = {sign, 8'hFF, 23'b0};
            end
            3'b111: begin
`ifdef BP_REC_TO_FP_CANON_NAN_EN
                dp_raw = 64'h7FF8_0000_0000_0000;
                sp_raw = 32'h7FC0_0000;
`else
                dp_raw = {sign, 11'h7FF, frac};
                sp_raw = {sign, 8'hFF, frac[51:29]};
`endif
            end
            default: begin
                if (dp_normal) begin
                    dp_raw = {sign, dp_biased, frac};
                end else begin
                    dp_raw = {sign, 11'b0, dp_sub};
                end
                if (sp_normal) begin
                    sp_raw = {sign, sp_biased, frac[51:29]};
                end else begin
                    sp_raw = {sign, 8'b0, sp_sub};
                end
            end
        endcase
    end

    assign raw_comb = sp_not_dp_i ? {32'hFFFF_FFFF, sp_raw} : dp_raw;

    // -----------------------------------------------------------------------
    // Output pipeline: valid and data shift together, no stall.
    // -----------------------------------------------------------------------
    generate
        if (num_stages_p == 0) begin : g_comb
            assign v_o   = v_i;
            assign raw_o = raw_comb;
        end else begin : g_pipe
            logic        v_reg   [num_stages_p];
            logic [63:0] raw_reg [num_stages_p];

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int i = 0; i < num_stages_p; i++) begin
                        v_reg[i]   <= 1'b0;
                        raw_reg[i] <= '0;
                    end
                end else begin
                    v_reg[0]   <= v_i;
                    raw_reg[0] <= raw_comb;
                    for (int i = 1; i < num_stages_p; i++) begin
                        v_reg[i]   <= v_reg[i-1];
                        raw_reg[i] <= raw_reg[i-1];
                    end
                end
            end

            assign v_o   = v_reg[num_stages_p-1];
            assign raw_o = raw_reg[num_stages_p-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Saturating conversion counter
    // -----------------------------------------------------------------------
    localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_val_p);

    logic [count_width_lp-1:0] count_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_reg <= '0;
        end else if (clear_i) begin
            count_reg <= '0;
        end else if (v_o && (count_reg != max_count_lp)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;

endmodule

// File: tb/tb_bp_be_rec_to_fp_pipe.sv
// ---------------------------------------------------------------------------
// tb_bp_be_rec_to_fp_pipe
//
// Directed scoreboard bench. The stimulus process pushes the hand-computed
// result and issue cycle of each conversion; a monitor pops and compares
// whenever v_o is high, checking both the value and the 4-cycle latency.
// A second instance with max_val_p = 3 shares the stimulus to observe
// counter saturation.
// ---------------------------------------------------------------------------
module tb_bp_be_rec_to_fp_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v_i = 1'b0;
    logic [64:0] rec = '0;
    logic        sp = 1'b0;
    logic        clear = 1'b0;

    logic        v_o;
    logic [63:0] raw_o;
    logic [30:0] count_o;

    logic        v_o2;
    logic [63:0] raw_o2;
    logic [1:0]  count_o2;

    always #5 clk = ~clk;

    bp_be_rec_to_fp_pipe #(.num_stages_p(4)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .v_i         (v_i),
        .rec_i       (rec),
        .sp_not_dp_i (sp),
        .clear_i     (clear),
        .v_o         (v_o),
        .raw_o       (raw_o),
        .count_o     (count_o)
    );

    bp_be_rec_to_fp_pipe #(.num_stages_p(4), .max_val_p(3)) dut_sat (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .v_i         (v_i),
        .rec_i       (rec),
        .sp_not_dp_i (sp),
        .clear_i     (clear),
        .v_o         (v_o2),
        .raw_o       (raw_o2),
        .count_o     (count_o2)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int n_issued   = 0;

    logic [63:0] exp_q [$];
    string       name_q [$];
    int          cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [64:0] mk(input logic s, input logic [11:0] e, input logic [51:0] f);
        return {s, e, f};
    endfunction

    // Monitor: one comparison of value and latency per output beat.
    always @(negedge clk) begin
        if (reset_n && v_o) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got %h required no output", raw_o);
            end else begin
                chk(name_q.pop_front(), raw_o, exp_q.pop_front());
                chk("latency", 64'(cyc - cyc_q.pop_front()), 64'd4);
            end
        end
    end

    task automatic issue(input string name, input logic [64:0] r, input logic s, input logic [63:0] req);
        @(posedge clk);
        #1;
        v_i = 1'b1;
        rec = r;
        sp  = s;
        exp_q.push_back(req);
        name_q.push_back(name);
        cyc_q.push_back(cyc);
        n_issued++;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        v_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] nan2_dp;
        int          waited;
`ifdef BP_REC_TO_FP_CANON_NAN_EN
        nan2_dp = 64'h7FF8_0000_0000_0000;
`else
        nan2_dp = 64'hFFF0_0000_0000_0001;
`endif
        // Reset state
        #3;
        chk("reset_v_o", 64'(v_o), 64'd0);
        chk("reset_raw_o", raw_o, 64'd0);
        chk("reset_count_o", 64'(count_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed conversions
        issue("one_dp",      mk(1'b0, 12'h800, 52'h0), 1'b0, 64'h3FF0_0000_0000_0000);
        issue("one_sp",      mk(1'b0, 12'h800, 52'h0), 1'b1, 64'hFFFF_FFFF_3F80_0000);
        issue("zero_dp",     65'h0,                    1'b0, 64'h0000_0000_0000_0000);
        issue("neginf_dp",   mk(1'b1, 12'hC00, 52'h0), 1'b0, 64'hFFF0_0000_0000_0000);
        issue("neginf_sp",   mk(1'b1, 12'hC00, 52'h0), 1'b1, 64'hFFFF_FFFF_FF80_0000);
        issue("qnan_dp",     mk(1'b0, 12'hE00, 52'h8_0000_0000_0000), 1'b0, 64'h7FF8_0000_0000_0000);
        issue("qnan_sp",     mk(1'b0, 12'hE00, 52'h8_0000_0000_0000), 1'b1, 64'hFFFF_FFFF_7FC0_0000);
        issue("nan_payload", mk(1'b1, 12'hE00, 52'h1), 1'b0, nan2_dp);
        issue("dp_min_sub",  mk(1'b0, 12'h3CE, 52'h0), 1'b0, 64'h0000_0000_0000_0001);
        issue("sp_min_sub",  mk(1'b0, 12'h76B, 52'h0), 1'b1, 64'hFFFF_FFFF_0000_0001);
        issue("dp_half_min", mk(1'b0, 12'h401, 52'h0), 1'b0, 64'h0008_0000_0000_0000);
        issue("two5_dp",     mk(1'b0, 12'h801, 52'h4_0000_0000_0000), 1'b0, 64'h4004_0000_0000_0000);
        issue("two5_sp",     mk(1'b0, 12'h801, 52'h4_0000_0000_0000), 1'b1, 64'hFFFF_FFFF_4020_0000);
        issue("dp_underflow", mk(1'b1, 12'h3CD, 52'h0), 1'b0, 64'h8000_0000_0000_0000);
        issue("sp_min_norm", mk(1'b0, 12'h782, 52'h0), 1'b1, 64'hFFFF_FFFF_0080_0000);
        drain();
        chk("count_directed", 64'(count_o), 64'(n_issued));
        chk("sat_count_directed", 64'(count_o2), 64'd3);

        // Idle clear
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n_issued = 0;
        chk("count_after_clear", 64'(count_o), 64'd0);
        chk("sat_count_after_clear", 64'(count_o2), 64'd0);

        // Back-to-back streaming of 10 values 2^0 .. 2^9
        for (int i = 0; i < 10; i++) begin
            issue($sformatf("stream_%0d", i), mk(1'b0, 12'h800 + 12'(i), 52'h0), 1'b0,
                  64'h3FF0_0000_0000_0000 + (64'(i) << 52));
        end
        drain();
        chk("count_stream", 64'(count_o), 64'(n_issued));
        chk("sat_count_stream", 64'(count_o2), 64'd3);

        // Clear coinciding with an output beat
        issue("clear_beat", mk(1'b0, 12'h800, 52'h0), 1'b0, 64'h3FF0_0000_0000_0000);
        @(posedge clk);
        #1;
        v_i = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!v_o && waited < 10);
        if (!v_o) begin
            compared++;
            mismatched++;
            $display("FAIL clear_beat_wait: got no v_o required v_o within 10 cycles");
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n_issued = 0;
        chk("count_clear_with_v_o", 64'(count_o), 64'd0);

        // Refill the counter, then reset while the pipeline is loaded
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("refill_%0d", i), mk(1'b1, 12'h800, 52'h0), 1'b0, 64'hBFF0_0000_0000_0000);
        end
        drain();
        chk("count_refill", 64'(count_o), 64'(n_issued));
        issue("inflight_0", mk(1'b0, 12'h800, 52'h0), 1'b0, 64'h3FF0_0000_0000_0000);
        issue("inflight_1", mk(1'b0, 12'h801, 52'h0), 1'b0, 64'h4000_0000_0000_0000);
        issue("inflight_2", mk(1'b0, 12'h802, 52'h0), 1'b0, 64'h4010_0000_0000_0000);
        issue("inflight_3", mk(1'b0, 12'h803, 52'h0), 1'b0, 64'h4020_0000_0000_0000);
        #1;
        reset_n = 1'b0;
        v_i = 1'b0;
        exp_q.delete();
        name_q.delete();
        cyc_q.delete();
        n_issued = 0;
        #1;
        chk("async_reset_v_o", 64'(v_o), 64'd0);
        chk("async_reset_raw_o", raw_o, 64'd0);
        chk("async_reset_count_o", 64'(count_o), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);

        // First conversion after reset release
        issue("post_reset", mk(1'b0, 12'h800, 52'h0), 1'b1, 64'hFFFF_FFFF_3F80_0000);
        drain();
        chk("count_post_reset", 64'(count_o), 64'(n_issued));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
